// File: rtl/lab2_qs_onchip_mem_arbiter_pkg.sv
// Shared widths and the command record used by the on-chip RAM arbiter.
package lab2_qs_mem_pkg;

  localparam int ADDR_W        = 14;
  localparam int DATA_W        = 32;
  localparam int BE_W          = 4;
  localparam int DEPTH_DEFAULT = 10000;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata;
    logic              rd;
    logic              wr;
  } cmd_t;

endpackage

// File: rtl/lab2_qs_onchip_mem_arbiter_if.sv
// One Avalon-MM requester port; the requester uses master, the arbiter uses slave.
interface lab2_qs_onchip_mem_arbiter_if;
  import lab2_qs_mem_pkg::*;

  logic [ADDR_W-1:0] address;
  logic [BE_W-1:0]   byteenable;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );

endinterface

// File: rtl/lab2_qs_onchip_mem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: the preferred requester keeps winning for up to
// MAX_BURST consecutive grants while the other one waits.
module lab2_qs_rr_arb2 #(
  parameter int MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       gnt_idx
);

  localparam logic [3:0] MAX_B = 4'(MAX_BURST);

  logic       prio_q;
  logic [3:0] burst_q;

  always_comb begin
    gnt_idx = 1'b0;
    case (req)
      2'b01:   gnt_idx = 1'b0;
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = (burst_q < MAX_B) ? prio_q : ~prio_q;
      default: gnt_idx = 1'b0;
    endcase
    gnt = (req == 2'b00) ? 2'b00 : (gnt_idx ? 2'b10 : 2'b01);
  end

  // An idle cycle ends the burst but keeps the preference.
  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q  <= 1'b0;
      burst_q <= 4'd0;
    end else if (req == 2'b00) begin
      burst_q <= 4'd0;
    end else if (gnt_idx == prio_q) begin
      if (burst_q < MAX_B) burst_q <= burst_q + 4'd1;
    end else begin
      prio_q  <= gnt_idx;
      burst_q <= 4'd1;
    end
  end

endmodule

// File: rtl/lab2_qs_onchip_mem_arbiter.sv
// Shares the single-port 10000x32 on-chip RAM between two Avalon-MM requesters,
// with range checking and a one-cycle read-return pipeline.
module lab2_qs_onchip_mem_arbiter
  import lab2_qs_mem_pkg::*;
#(
  parameter int                DEPTH          = DEPTH_DEFAULT,
  parameter int                MAX_BURST      = 4,
  parameter logic [DATA_W-1:0] OOR_READ_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  lab2_qs_onchip_mem_arbiter_if.slave m0,
  lab2_qs_onchip_mem_arbiter_if.slave m1,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [BE_W-1:0]       mem_byteenable,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [DATA_W-1:0]     mem_writedata,
  output logic                  mem_clken,
  input  logic [DATA_W-1:0]     mem_readdata,
  output logic                  oor_err,
  output logic                  oor_err_port
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  cmd_t       cmd0, cmd1, gcmd;
  logic [1:0] req, gnt;
  logic       gnt_idx, gnt_valid, in_range;
  logic       rd_vld_q, rd_port_q, rd_oor_q;

  always_comb begin
    cmd0 = '{addr: m0.address, be: m0.byteenable, wdata: m0.writedata,
             rd: m0.read, wr: m0.write};
    cmd1 = '{addr: m1.address, be: m1.byteenable, wdata: m1.writedata,
             rd: m1.read, wr: m1.write};
  end

  // Requests are masked during reset so nothing is granted or sent to the RAM.
  assign req = {cmd1.rd | cmd1.wr, cmd0.rd | cmd0.wr} & {2{~reset}};

  lab2_qs_rr_arb2 #(.MAX_BURST(MAX_BURST)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign gnt_valid = |gnt;
  assign gcmd      = gnt_idx ? cmd1 : cmd0;
  assign in_range  = {1'b0, gcmd.addr} < DEPTH_L;

  assign mem_address    = gcmd.addr;
  assign mem_byteenable = gcmd.be;
  assign mem_writedata  = gcmd.wdata;
  assign mem_chipselect = gnt_valid & in_range;
  assign mem_write      = gnt_valid & gcmd.wr & in_range;
  assign mem_clken      = 1'b1;

  assign m0.waitrequest = ~gnt[0];
  assign m1.waitrequest = ~gnt[1];

  // A read pending across a reset cycle is dropped rather than returned.
  assign m0.readdatavalid = rd_vld_q & ~reset & (rd_port_q == 1'b0);
  assign m1.readdatavalid = rd_vld_q & ~reset & (rd_port_q == 1'b1);
  assign m0.readdata      = rd_oor_q ? OOR_READ_VALUE : mem_readdata;
  assign m1.readdata      = rd_oor_q ? OOR_READ_VALUE : mem_readdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_vld_q     <= 1'b0;
      rd_port_q    <= 1'b0;
      rd_oor_q     <= 1'b0;
      oor_err      <= 1'b0;
      oor_err_port <= 1'b0;
    end else begin
      rd_vld_q <= gnt_valid & ~gcmd.wr;
      if (gnt_valid && !gcmd.wr) begin
        rd_port_q <= gnt_idx;
        rd_oor_q  <= ~in_range;
      end
      if (gnt_valid && !in_range) begin
        oor_err <= 1'b1;
        if (!oor_err) oor_err_port <= gnt_idx;
      end
    end
  end

endmodule
